// File: rtl/task5_baccarat.sv
// rtl/task5_baccarat.sv - single-clock baccarat engine: card counter, game FSM, 7-seg and LED outputs.
// Optional STEP_EDGE_DETECT_EN: advance only on rising edges of step.
module task5_baccarat (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       step,
    output logic [9:0] LEDR,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5
);

    typedef enum logic [2:0] {
        S_PC1, S_DC1, S_PC2, S_DC2, S_EVAL, S_PC3, S_DC3, S_WIN
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] pcard1_q, pcard1_d, pcard2_q, pcard2_d, pcard3_q, pcard3_d;
    logic [3:0] dcard1_q, dcard1_d, dcard2_q, dcard2_d, dcard3_q, dcard3_d;
    logic [3:0] pscore, dscore;
    logic       advance;

    function automatic logic [3:0] card_value(input logic [3:0] c);
        return (c >= 4'd1 && c <= 4'd9) ? c : 4'd0;
    endfunction

    function automatic logic [3:0] side_score(input logic [3:0] c1, input logic [3:0] c2,
                                              input logic [3:0] c3);
        logic [4:0] sum;
        sum = {1'b0, card_value(c1)} + {1'b0, card_value(c2)} + {1'b0, card_value(c3)};
        if (sum >= 5'd20)
            sum = sum - 5'd20;
        else if (sum >= 5'd10)
            sum = sum - 5'd10;
        return sum[3:0];
    endfunction

    // Banker rule after the player has drawn a third card of value t.
    function automatic logic dealer_draws(input logic [3:0] ds, input logic [3:0] t);
        logic d;
        case (ds)
            4'd0, 4'd1, 4'd2: d = 1'b1;
            4'd3:             d = (t != 4'd8);
            4'd4:             d = (t >= 4'd2 && t <= 4'd7);
            4'd5:             d = (t >= 4'd4 && t <= 4'd7);
            4'd6:             d = (t >= 4'd6 && t <= 4'd7);
            default:          d = 1'b0;
        endcase
        return d;
    endfunction

    function automatic logic [6:0] hex_of(input logic [3:0] c);
        logic [6:0] h;
        case (c)
            4'd1:    h = 7'b0001000;
            4'd2:    h = 7'b0100100;
            4'd3:    h = 7'b0110000;
            4'd4:    h = 7'b0011001;
            4'd5:    h = 7'b0010010;
            4'd6:    h = 7'b0000010;
            4'd7:    h = 7'b1111000;
            4'd8:    h = 7'b0000000;
            4'd9:    h = 7'b0010000;
            4'd10:   h = 7'b1000000;
            4'd11:   h = 7'b1100001;
            4'd12:   h = 7'b0011000;
            4'd13:   h = 7'b0001001;
            default: h = 7'b1111111;
        endcase
        return h;
    endfunction

`ifdef STEP_EDGE_DETECT_EN
    logic step_q, step_d;

    always_comb begin
        step_d = step;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset)
            step_q <= 1'b0;
        else
            step_q <= step_d;
    end

    assign advance = step & ~step_q;
`else
    assign advance = step;
`endif

    assign pscore = side_score(pcard1_q, pcard2_q, pcard3_q);
    assign dscore = side_score(dcard1_q, dcard2_q, dcard3_q);

    always_comb begin
        cnt_d    = (cnt_q == 4'd13) ? 4'd1 : cnt_q + 4'd1;
        state_d  = state_q;
        pcard1_d = pcard1_q;
        pcard2_d = pcard2_q;
        pcard3_d = pcard3_q;
        dcard1_d = dcard1_q;
        dcard2_d = dcard2_q;
        dcard3_d = dcard3_q;
        if (advance) begin
            case (state_q)
                S_PC1: begin pcard1_d = cnt_q; state_d = S_DC1; end
                S_DC1: begin dcard1_d = cnt_q; state_d = S_PC2; end
                S_PC2: begin pcard2_d = cnt_q; state_d = S_DC2; end
                S_DC2: begin dcard2_d = cnt_q; state_d = S_EVAL; end
                S_EVAL: begin
                    if (pscore >= 4'd8 || dscore >= 4'd8)
                        state_d = S_WIN;
                    else if (pscore <= 4'd5)
                        state_d = S_PC3;
                    else if (dscore <= 4'd5)
                        state_d = S_DC3;
                    else
                        state_d = S_WIN;
                end
                S_PC3: begin
                    pcard3_d = cnt_q;
                    state_d  = dealer_draws(dscore, card_value(cnt_q)) ? S_DC3 : S_WIN;
                end
                S_DC3: begin dcard3_d = cnt_q; state_d = S_WIN; end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q  <= S_PC1;
            cnt_q    <= 4'd1;
            pcard1_q <= 4'd0;
            pcard2_q <= 4'd0;
            pcard3_q <= 4'd0;
            dcard1_q <= 4'd0;
            dcard2_q <= 4'd0;
            dcard3_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pcard1_q <= pcard1_d;
            pcard2_q <= pcard2_d;
            pcard3_q <= pcard3_d;
            dcard1_q <= dcard1_d;
            dcard2_q <= dcard2_d;
            dcard3_q <= dcard3_d;
        end
    end

    always_comb begin
        LEDR[3:0] = pscore;
        LEDR[7:4] = dscore;
        LEDR[8]   = (state_q == S_WIN) && (pscore >= dscore);
        LEDR[9]   = (state_q == S_WIN) && (dscore >= pscore);
        HEX0      = hex_of(pcard1_q);
        HEX1      = hex_of(pcard2_q);
        HEX2      = hex_of(pcard3_q);
        HEX3      = hex_of(dcard1_q);
        HEX4      = hex_of(dcard2_q);
        HEX5      = hex_of(dcard3_q);
    end

endmodule

// File: tb/tb_task5_baccarat.sv
// tb/tb_task5_baccarat.sv - self-checking bench for task5_baccarat against a game-rule model.
module tb_task5_baccarat;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       step = 1'b0;
    logic [9:0] LEDR;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    int checks = 0;
    int errors = 0;

    // Model: cards dealt so far, counter value, and which game stage comes next.
    int m_cnt;
    int m_p[3];
    int m_d[3];
    int m_stage;   // 0 PC1, 1 DC1, 2 PC2, 3 DC2, 4 EVAL, 5 PC3, 6 DC3, 7 WIN
    bit m_stepq;

    always #5 clk = ~clk;

    task5_baccarat dut (
        .CLOCK_50(clk), .reset(reset), .step(step), .LEDR(LEDR),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
    );

    function automatic int val(input int c);
        return (c >= 1 && c <= 9) ? c : 0;
    endfunction

    function automatic int pscore();
        return (val(m_p[0]) + val(m_p[1]) + val(m_p[2])) % 10;
    endfunction

    function automatic int dscore();
        return (val(m_d[0]) + val(m_d[1]) + val(m_d[2])) % 10;
    endfunction

    function automatic bit banker_draws(input int ds, input int t);
        if (ds <= 2) return 1'b1;
        if (ds == 3) return t != 8;
        if (ds == 4) return t >= 2 && t <= 7;
        if (ds == 5) return t >= 4 && t <= 7;
        if (ds == 6) return t >= 6 && t <= 7;
        return 1'b0;
    endfunction

    function automatic logic [6:0] seg(input int c);
        case (c)
            1: return 7'b0001000;   2: return 7'b0100100;   3: return 7'b0110000;
            4: return 7'b0011001;   5: return 7'b0010010;   6: return 7'b0000010;
            7: return 7'b1111000;   8: return 7'b0000000;   9: return 7'b0010000;
            10: return 7'b1000000;  11: return 7'b1100001;  12: return 7'b0011000;
            13: return 7'b0001001;  default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [51:0] model_out();
        logic wp, wd;
        wp = (m_stage == 7) && (pscore() >= dscore());
        wd = (m_stage == 7) && (dscore() >= pscore());
        return {seg(m_d[2]), seg(m_d[1]), seg(m_d[0]), seg(m_p[2]), seg(m_p[1]), seg(m_p[0]),
                wd, wp, 4'(dscore()), 4'(pscore())};
    endfunction

    function automatic logic [51:0] dut_out();
        return {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0, LEDR};
    endfunction

    task automatic model_edge(input bit s, input bit r);
        bit adv;
        int ps, ds;
        if (r) begin
            m_p = '{0, 0, 0}; m_d = '{0, 0, 0};
            m_cnt = 1; m_stage = 0; m_stepq = 1'b0;
            return;
        end
`ifdef STEP_EDGE_DETECT_EN
        adv = s && !m_stepq;
`else
        adv = s;
`endif
        m_stepq = s;
        ps = pscore();
        ds = dscore();
        if (adv) begin
            case (m_stage)
                0: begin m_p[0] = m_cnt; m_stage = 1; end
                1: begin m_d[0] = m_cnt; m_stage = 2; end
                2: begin m_p[1] = m_cnt; m_stage = 3; end
                3: begin m_d[1] = m_cnt; m_stage = 4; end
                4: begin
                    if (ps >= 8 || ds >= 8) m_stage = 7;
                    else if (ps <= 5)       m_stage = 5;
                    else if (ds <= 5)       m_stage = 6;
                    else                    m_stage = 7;
                end
                5: begin
                    m_p[2] = m_cnt;
                    m_stage = banker_draws(ds, val(m_cnt)) ? 6 : 7;
                end
                6: begin m_d[2] = m_cnt; m_stage = 7; end
                default: ;
            endcase
        end
        m_cnt = (m_cnt == 13) ? 1 : m_cnt + 1;
    endtask

    task automatic tick(input bit s, input bit r);
        @(negedge clk);
        step  = s;
        reset = r;
        @(posedge clk);
        model_edge(s, r);
        #1;
        step = 1'b0;
    endtask

    // Idle until the model counter shows the wanted card, then advance on it.
    task automatic deal(input int card);
        for (int i = 0; i < 13 && m_cnt != card; i++) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
    endtask

    task automatic test_reset();
        tick(1'b0, 1'b1);
        checks++;
        if ({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} !== {6{7'b1111111}} || LEDR !== 10'd0) begin
            errors++;
            $display("FAIL reset: got hex=%h ledr=%h required hex=%h ledr=000",
                     {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, LEDR, {6{7'b1111111}});
        end
    endtask

    task automatic test_first_ace();
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b0);
        checks++;
        if (HEX0 !== 7'b0001000 || LEDR !== 10'd1 || HEX3 !== 7'b1111111) begin
            errors++;
            $display("FAIL first_ace: got hex0=%b ledr=%h required hex0=0001000 ledr=001", HEX0, LEDR);
        end
    endtask

    task automatic test_dealer_four();
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        checks++;
        if (HEX3 !== 7'b0011001 || LEDR !== {2'b00, 4'd4, 4'd1}) begin
            errors++;
            $display("FAIL dealer_four: got hex3=%b ledr=%h required hex3=0011001 ledr=041", HEX3, LEDR);
        end
    endtask

    task automatic test_player_natural();
        tick(1'b0, 1'b1);
        deal(1); deal(1); deal(8); deal(11);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        checks++;
        if (LEDR !== {1'b0, 1'b1, 4'd1, 4'd9}) begin
            errors++;
            $display("FAIL player_natural: got ledr=%h required %h", LEDR, {1'b0, 1'b1, 4'd1, 4'd9});
        end
    endtask

    task automatic test_dealer_natural();
        tick(1'b0, 1'b1);
        deal(1); deal(1); deal(1); deal(8);
        tick(1'b1, 1'b0);
        checks++;
        if (LEDR !== {1'b1, 1'b0, 4'd9, 4'd2}) begin
            errors++;
            $display("FAIL dealer_natural: got ledr=%h required %h", LEDR, {1'b1, 1'b0, 4'd9, 4'd2});
        end
    endtask

    task automatic test_tie_path();
        tick(1'b0, 1'b1);
        deal(1); deal(1); deal(1); deal(1);
        tick(1'b1, 1'b0);
        deal(1); deal(1);
        checks++;
        if ({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} !== {6{7'b0001000}} ||
            LEDR !== {1'b1, 1'b1, 4'd3, 4'd3}) begin
            errors++;
            $display("FAIL tie_path: got hex=%h ledr=%h required hex=%h ledr=333",
                     {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, LEDR, {6{7'b0001000}});
        end
        tick(1'b0, 1'b1);
        deal(1); deal(1); deal(1); deal(1);
        tick(1'b1, 1'b0);
        deal(10);
        checks++;
        if (HEX2 !== 7'b1000000 || LEDR !== {2'b00, 4'd2, 4'd2} || m_stage != 6) begin
            errors++;
            $display("FAIL tie_ten_pcard3: got hex2=%b ledr=%h required hex2=1000000 ledr=022", HEX2, LEDR);
        end
    endtask

    task automatic test_reset_wins();
        tick(1'b0, 1'b1);
        deal(5); deal(7);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        checks++;
        if (dut_out() !== model_out() || HEX0 !== 7'b0001000) begin
            errors++;
            $display("FAIL reset_wins: got %h required %h", dut_out(), model_out());
        end
    endtask

    task automatic test_random_games();
        for (int g = 0; g < 40; g++) begin
            tick(1'b0, 1'b1);
            for (int k = 0; k < 9; k++) begin
                if ($urandom_range(0, 11) == 0) begin
                    tick(1'b1, 1'b1);
                end else if (m_stage == 4 || m_stage == 7) begin
                    tick(1'b1, 1'b0);
                end else begin
                    deal(int'($urandom_range(1, 13)));
                end
                checks++;
                if (dut_out() !== model_out()) begin
                    errors++;
                    $display("FAIL random_game %0d step %0d: got %h required %h",
                             g, k, dut_out(), model_out());
                end
            end
        end
    endtask

    initial begin
        m_p = '{0, 0, 0};
        m_d = '{0, 0, 0};
        m_cnt = 1; m_stage = 0; m_stepq = 1'b0;
        test_reset();
        test_first_ace();
        test_dealer_four();
        test_player_natural();
        test_dealer_natural();
        test_tie_path();
        test_reset_wins();
        test_random_games();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
